// File: rtl/instruction_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_loader_pkg
// Description : Shared pipeline constants for the instruction loader and the
//               debug/UART unit: byte/word widths, instruction memory address
//               width, end-of-program marker and loader state encoding.
//               The CHECK state is only reachable when LOADER_CHECKSUM_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_loader_pkg;

    localparam int unsigned c_nb_byte   = 8;
    localparam int unsigned c_nb_data   = 32;
    localparam int unsigned c_pc_width  = 9;

    localparam logic [c_nb_data-1:0] c_halt_word = 32'hFFFF_FFFF;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_receive = 2'd1;
    localparam logic [1:0] c_st_write   = 2'd2;
    localparam logic [1:0] c_st_done    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = c_st_idle,
        ST_RECEIVE = c_st_receive,
        ST_WRITE   = c_st_write,
        ST_DONE    = c_st_done
    } loader_state_t;

    // CHECK shares no encoding with the main states; it lives in a 3-bit
    // space only when the checksum feature is built.
    localparam logic [2:0] c_st_check = 3'd4;

endpackage : instruction_loader_pkg
`default_nettype wire

// File: rtl/instruction_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : instruction_loader_byte_packer
// Description : Packs an MSB-first byte stream into words. Keeps the lower
//               three bytes in a shift register and counts accepted bytes
//               with a 2-bit counter. o_word_ready is raised combinationally
//               on the accepted 4th byte, with o_word_next holding the full
//               word at that moment so the caller can register it.
// Ports       : i_clk, i_reset (async, active-low), i_clear (restart count),
//               i_valid / i_byte (accepted byte), o_word_next, o_word_ready
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_loader_byte_packer #(
    parameter int unsigned NB_BYTE = 8,
    parameter int unsigned NB_DATA = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_valid,
    input  logic [NB_BYTE-1:0] i_byte,
    output logic [NB_DATA-1:0] o_word_next,
    output logic               o_word_ready
);

    logic [NB_DATA-NB_BYTE-1:0] r_word;
    logic [1:0]                 r_count;

    assign o_word_next  = {r_word, i_byte};
    assign o_word_ready = i_valid && !i_clear && (r_count == 2'd3);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_word  <= '0;
            r_count <= 2'd0;
        end else if (i_clear) begin
            r_word  <= '0;
            r_count <= 2'd0;
        end else if (i_valid) begin
            r_word  <= o_word_next[NB_DATA-NB_BYTE-1:0];
            r_count <= r_count + 2'd1;
        end
    end

endmodule : instruction_loader_byte_packer
`default_nettype wire

// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : instruction_loader
// Description : Loads a program image from the UART byte stream into the
//               instruction memory. Bytes are packed MSB first into words and
//               written at consecutive word addresses starting at 0. The CPU
//               pipeline is held disabled while loading. The load ends on the
//               halt word (which is itself written) or when the last word of
//               memory has been written (o_full).
//               Optional feature macro: LOADER_CHECKSUM_EN - after the halt
//               word one checksum byte (XOR of all received bytes) is expected;
//               a mismatch sets the sticky o_checksum_err output.
// Ports       : i_clk, i_reset (async, active-low), i_start, i_rx_data,
//               i_rx_valid, o_imem_we, o_imem_addr, o_imem_data,
//               o_cpu_enable, o_busy, o_done, o_full [, o_checksum_err]
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int unsigned          PC_WIDTH  = c_pc_width,
    parameter int unsigned          NB_DATA   = c_nb_data,
    parameter int unsigned          NB_BYTE   = c_nb_byte,
    parameter logic [NB_DATA-1:0]   HALT_WORD = c_halt_word
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_BYTE-1:0]  i_rx_data,
    input  logic                i_rx_valid,
    output logic                o_imem_we,
    output logic [PC_WIDTH-1:0] o_imem_addr,
    output logic [NB_DATA-1:0]  o_imem_data,
    output logic                o_cpu_enable,
    output logic                o_busy,
    output logic                o_done,
`ifdef LOADER_CHECKSUM_EN
    output logic                o_checksum_err,
`endif
    output logic                o_full
);

    localparam logic [PC_WIDTH-1:0] c_last_addr = {{(PC_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [PC_WIDTH-1:0] c_addr_step = PC_WIDTH'(4);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE    = {1'b0, c_st_idle},
        S_RECEIVE = {1'b0, c_st_receive},
        S_WRITE   = {1'b0, c_st_write},
        S_DONE    = {1'b0, c_st_done},
        S_CHECK   = c_st_check
    } state_t;
`else
    typedef loader_state_t state_t;
    localparam state_t S_IDLE    = ST_IDLE;
    localparam state_t S_RECEIVE = ST_RECEIVE;
    localparam state_t S_WRITE   = ST_WRITE;
    localparam state_t S_DONE    = ST_DONE;
`endif

    state_t                r_state;
    state_t                w_state_next;

    logic                  r_imem_we;
    logic [PC_WIDTH-1:0]   r_imem_addr;
    logic [NB_DATA-1:0]    r_imem_data;
    logic                  r_cpu_enable;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_full;

    logic                  w_start;
    logic                  w_is_halt;
    logic                  w_is_last;
    logic                  w_continue;
    logic                  w_accept;
    logic [NB_DATA-1:0]    w_word_next;
    logic                  w_word_ready;

    // Start is only honoured when no load is in progress.
    assign w_start    = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_is_halt  = (r_imem_data == HALT_WORD);
    assign w_is_last  = (r_imem_addr == c_last_addr);
    // A WRITE that is followed by another word; a byte landing in this cycle
    // is byte 0 of that next word.
    assign w_continue = (r_state == S_WRITE) && !w_is_halt && !w_is_last;
    assign w_accept   = i_rx_valid && ((r_state == S_RECEIVE) || w_continue);

    instruction_loader_byte_packer #(
        .NB_BYTE (NB_BYTE),
        .NB_DATA (NB_DATA)
    ) u_byte_packer (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (w_start),
        .i_valid      (w_accept),
        .i_byte       (i_rx_data),
        .o_word_next  (w_word_next),
        .o_word_ready (w_word_ready)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [NB_BYTE-1:0] r_xor;
    logic               r_checksum_err;
    logic               w_chk_byte;

    // The checksum byte may already arrive during the halt WRITE cycle.
    assign w_chk_byte = i_rx_valid &&
                        ((r_state == S_CHECK) || ((r_state == S_WRITE) && w_is_halt));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_xor          <= '0;
            r_checksum_err <= 1'b0;
        end else if (w_start) begin
            r_xor          <= '0;
            r_checksum_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_xor <= r_xor ^ i_rx_data;
            end
            if (w_chk_byte && (i_rx_data != r_xor)) begin
                r_checksum_err <= 1'b1;
            end
        end
    end

    assign o_checksum_err = r_checksum_err;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    w_state_next = S_RECEIVE;
                end
            end
            S_RECEIVE: begin
                if (w_word_ready) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_is_halt) begin
`ifdef LOADER_CHECKSUM_EN
                    w_state_next = i_rx_valid ? S_DONE : S_CHECK;
`else
                    w_state_next = S_DONE;
`endif
                end else if (w_is_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_RECEIVE;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (i_rx_valid) begin
                    w_state_next = S_DONE;
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_data  <= '0;
            r_cpu_enable <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_full       <= 1'b0;
        end else begin
            r_imem_we    <= (w_state_next == S_WRITE);
            r_cpu_enable <= (w_state_next == S_IDLE) || (w_state_next == S_DONE);
            // The pipeline stays held while waiting for a checksum byte.
            r_busy       <= !((w_state_next == S_IDLE) || (w_state_next == S_DONE));

            if (w_word_ready) begin
                r_imem_data <= w_word_next;
            end

            if (w_start) begin
                r_imem_addr <= '0;
                r_done      <= 1'b0;
                r_full      <= 1'b0;
            end else begin
                if (w_continue) begin
                    r_imem_addr <= r_imem_addr + c_addr_step;
                end
                if (w_state_next == S_DONE) begin
                    r_done <= 1'b1;
                end
                if ((r_state == S_WRITE) && !w_is_halt && w_is_last) begin
                    r_full <= 1'b1;
                end
            end
        end
    end

    assign o_imem_we    = r_imem_we;
    assign o_imem_addr  = r_imem_addr;
    assign o_imem_data  = r_imem_data;
    assign o_cpu_enable = r_cpu_enable;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_full       = r_full;

endmodule : instruction_loader
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_loader
// Description : Directed self-checking bench for instruction_loader. Drives
//               the byte stream and start pulses, logs every memory write
//               and compares against hand-computed values.
//               Optional feature macro: LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_loader;

    logic        i_clk      = 1'b0;
    logic        i_reset    = 1'b0;
    logic        i_start    = 1'b0;
    logic [7:0]  i_rx_data  = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic        o_imem_we;
    logic [8:0]  o_imem_addr;
    logic [31:0] o_imem_data;
    logic        o_cpu_enable;
    logic        o_busy;
    logic        o_done;
    logic        o_full;
`ifdef LOADER_CHECKSUM_EN
    logic        o_checksum_err;
`endif

    int total = 0;
    int bad   = 0;

    logic [8:0]  log_addr[$];
    logic [31:0] log_data[$];

    instruction_loader dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_rx_data      (i_rx_data),
        .i_rx_valid     (i_rx_valid),
        .o_imem_we      (o_imem_we),
        .o_imem_addr    (o_imem_addr),
        .o_imem_data    (o_imem_data),
        .o_cpu_enable   (o_cpu_enable),
        .o_busy         (o_busy),
        .o_done         (o_done),
`ifdef LOADER_CHECKSUM_EN
        .o_checksum_err (o_checksum_err),
`endif
        .o_full         (o_full)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_imem_we === 1'b1) begin
            log_addr.push_back(o_imem_addr);
            log_data.push_back(o_imem_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // Called in the halt WRITE cycle; takes exactly one cycle either way.
    task automatic end_load();
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00);
`else
        idle(1);
`endif
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_we"},   {31'd0, o_imem_we},    32'd0);
        chk({tag, "_addr"}, {23'd0, o_imem_addr},  32'd0);
        chk({tag, "_data"}, o_imem_data,           32'd0);
        chk({tag, "_cpu"},  {31'd0, o_cpu_enable}, 32'd1);
        chk({tag, "_busy"}, {31'd0, o_busy},       32'd0);
        chk({tag, "_done"}, {31'd0, o_done},       32'd0);
        chk({tag, "_full"}, {31'd0, o_full},       32'd0);
    endtask

    initial begin
        // Reset and idle behaviour
        idle(3);
        chk_reset_values("reset");
        i_reset = 1'b1;
        idle(1);
        send_word(32'h1234_5678);
        idle(3);
        chk("idle_no_write", log_addr.size(), 0);
        chk("idle_cpu", {31'd0, o_cpu_enable}, 32'd1);

        // Two-word load with gaps, ending on the halt word
        pulse_start();
        chk("start_cpu_fall", {31'd0, o_cpu_enable}, 32'd0);
        chk("start_busy",     {31'd0, o_busy},       32'd1);
        send_byte(8'h12); idle(1);
        send_byte(8'h34); idle(2);
        send_byte(8'h56); idle(1);
        send_byte(8'h78);
        chk("w0_we_latency", {31'd0, o_imem_we},   32'd1);
        chk("w0_addr",       {23'd0, o_imem_addr}, 32'h0);
        chk("w0_data",       o_imem_data,          32'h1234_5678);
        idle(2);
        send_word(32'hFFFF_FFFF);
        chk("halt_we",  {31'd0, o_imem_we},    32'd1);
        chk("halt_cpu", {31'd0, o_cpu_enable}, 32'd0);
        end_load();
        chk("halt_cpu_rise", {31'd0, o_cpu_enable}, 32'd1);
        idle(2);
        chk("load1_count",  log_addr.size(), 2);
        chk("load1_a0",     {23'd0, log_addr[0]}, 32'h0);
        chk("load1_d0",     log_data[0],          32'h1234_5678);
        chk("load1_a1",     {23'd0, log_addr[1]}, 32'h4);
        chk("load1_d1",     log_data[1],          32'hFFFF_FFFF);
        chk("load1_done",   {31'd0, o_done}, 32'd1);
        chk("load1_full",   {31'd0, o_full}, 32'd0);
        chk("load1_busy",   {31'd0, o_busy}, 32'd0);

        // Back-to-back bytes: byte 0 of word 2 arrives in the WRITE cycle
        log_addr.delete(); log_data.delete();
        pulse_start();
        chk("restart_done_clr", {31'd0, o_done}, 32'd0);
        send_word(32'hAABB_CCDD);
        send_word(32'h1122_3344);
        send_word(32'hFFFF_FFFF);
        end_load();
        idle(3);
        chk("b2b_count", log_addr.size(), 3);
        chk("b2b_d0",    log_data[0],          32'hAABB_CCDD);
        chk("b2b_a1",    {23'd0, log_addr[1]}, 32'h4);
        chk("b2b_d1",    log_data[1],          32'h1122_3344);
        chk("b2b_a2",    {23'd0, log_addr[2]}, 32'h8);
        chk("b2b_d2",    log_data[2],          32'hFFFF_FFFF);

        // Fill all 128 words without a halt word
        log_addr.delete(); log_data.delete();
        pulse_start();
        for (int i = 0; i < 128; i++) begin
            send_word({8'(i), 8'h5A, 8'h00, 8'(i ^ 1)});
        end
        idle(3);
        chk("full_count", log_addr.size(), 128);
        chk("full_a64",   {23'd0, log_addr[64]},  32'h100);
        chk("full_a127",  {23'd0, log_addr[127]}, 32'h1FC);
        chk("full_d127",  log_data[127],          32'h7F5A_007E);
        chk("full_full",  {31'd0, o_full},       32'd1);
        chk("full_done",  {31'd0, o_done},       32'd1);
        chk("full_cpu",   {31'd0, o_cpu_enable}, 32'd1);
        send_word(32'h0102_0304);
        idle(3);
        chk("full_ignore", log_addr.size(), 128);

        // Reset mid-load, then a fresh load from address 0
        log_addr.delete(); log_data.delete();
        pulse_start();
        chk("restart_full_clr", {31'd0, o_full}, 32'd0);
        send_word(32'h0000_0001);
        send_word(32'h0000_0002);
        send_byte(8'hDE);
        send_byte(8'hAD);
        i_reset = 1'b0;
        #1;
        chk_reset_values("midrst");
        @(negedge i_clk);
        i_reset = 1'b1;
        idle(1);
        chk("midrst_count", log_addr.size(), 2);
        log_addr.delete(); log_data.delete();
        pulse_start();
        send_byte(8'h0A);
        send_byte(8'h0B);
        pulse_start();
        send_byte(8'h0C);
        send_byte(8'h0D);
        chk("reload_we",   {31'd0, o_imem_we},   32'd1);
        chk("reload_addr", {23'd0, o_imem_addr}, 32'h0);
        chk("reload_data", o_imem_data,          32'h0A0B_0C0D);
        send_word(32'hFFFF_FFFF);
        end_load();
        idle(3);
        chk("reload_count", log_addr.size(), 2);
        chk("reload_a1",    {23'd0, log_addr[1]}, 32'h4);

`ifdef LOADER_CHECKSUM_EN
        // Checksum byte after the CHECK wait: 01^02^03^04 = 04
        pulse_start();
        chk("ck_clr", {31'd0, o_checksum_err}, 32'd0);
        send_word(32'h0102_0304);
        send_word(32'hFFFF_FFFF);
        idle(2);
        chk("ck_wait_cpu",  {31'd0, o_cpu_enable}, 32'd0);
        chk("ck_wait_done", {31'd0, o_done},       32'd0);
        send_byte(8'h04);
        idle(1);
        chk("ck_good_done", {31'd0, o_done},         32'd1);
        chk("ck_good_err",  {31'd0, o_checksum_err}, 32'd0);
        pulse_start();
        send_word(32'h0102_0304);
        send_word(32'hFFFF_FFFF);
        idle(2);
        send_byte(8'h05);
        idle(1);
        chk("ck_bad_done", {31'd0, o_done},         32'd1);
        chk("ck_bad_err",  {31'd0, o_checksum_err}, 32'd1);
        pulse_start();
        chk("ck_err_clr",  {31'd0, o_checksum_err}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instruction_loader
`default_nettype wire
